// File: rtl/seq_mul_iter.sv
// Iterative shift-add multiplier: one WIDTH-bit adder reused over WIDTH steps,
// with optional two's-complement mode and valid/ready on both sides.
module seq_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    p_d      = p_q;
    sum      = '0;
    prod     = '0;

    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Carry lands in sum[WIDTH] and becomes the new accumulator MSB after the shift.
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          prod    = {acc_d, mplier_d};
          p_d     = neg_q ? -prod : prod;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_mul_iter.sv
// Self-checking bench for seq_mul_iter: WIDTH=8 directed vectors and corner
// sequences, plus an exhaustive WIDTH=4 run with random stalls.
module tb_seq_mul_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        iv8 = 1'b0, or8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8;
  logic [15:0] p8;

  // WIDTH=4 instance
  logic        iv4 = 1'b0, or4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ir4, ov4;
  logic [7:0]  p4;

  seq_mul_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  seq_mul_iter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer multiply of the interpreted operands, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input bit sm);
    longint sx, sy, pr;
    logic [63:0] mask;
    sx = longint'({32'b0, x});
    sy = longint'({32'b0, y});
    if (sm && x[w-1]) sx = sx - (longint'(1) << w);
    if (sm && y[w-1]) sy = sy - (longint'(1) << w);
    pr   = sx * sy;
    mask = (64'(1) << (2 * w)) - 64'(1);
    return 64'(pr) & mask;
  endfunction

  // Issue one operation on the 8-bit DUT (called #1 after an edge); checks latency and p.
  task automatic do_op8(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input bit sm, input logic [15:0] exp);
    int lat;
    bit ir_hi;
    check({nm, "_in_ready_idle"}, 64'(ir8), 64'(1));
    a8 = x; b8 = y; sm8 = sm; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    ir_hi = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ov8) begin
        lat = k;
        break;
      end
      if (ir8) ir_hi = 1'b1;
    end
    check({nm, "_latency"}, 64'(lat), 64'(8));
    check({nm, "_in_ready_busy"}, 64'(ir_hi), 64'(0));
    check({nm, "_p"}, 64'(p8), 64'(exp));
  endtask

  task automatic release8(input string nm);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check({nm, "_out_valid_clr"}, 64'(ov8), 64'(0));
    check({nm, "_in_ready_back"}, 64'(ir8), 64'(1));
  endtask

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [63:0] fq[$];
    logic [63:0] q4[$];
    int nprod, last_cyc, idx, got;
    logic [8:0] idx9;

    vecs[0] = '{"u_ff_ff",     8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1] = '{"s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2] = '{"s_m3_5",      8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[3] = '{"s_80_01",     8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[4] = '{"u_fd_05",     8'hFD, 8'h05, 1'b0, 16'h04F1};
    vecs[5] = '{"s_127_m127",  8'h7F, 8'h81, 1'b1, 16'hC0FF};
    vecs[6] = '{"s_0_m1",      8'h00, 8'hFF, 1'b1, 16'h0000};
    vecs[7] = '{"u_0_0",       8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[8] = '{"s_m1_m1",     8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9] = '{"u_80_02",     8'h80, 8'h02, 1'b0, 16'h0100};

    // Reset values
    #3;
    check("rst_in_ready8", 64'(ir8), 64'(1));
    check("rst_out_valid8", 64'(ov8), 64'(0));
    check("rst_p8", 64'(p8), 64'(0));
    check("rst_in_ready4", 64'(ir4), 64'(1));
    check("rst_p4", 64'(p4), 64'(0));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle has no effect
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("idle_out_ready_ov", 64'(ov8), 64'(0));
    check("idle_out_ready_ir", 64'(ir8), 64'(1));

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      do_op8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
      release8(vecs[i].name);
      check({vecs[i].name, "_p_hold"}, 64'(p8), 64'(vecs[i].exp));
    end

    // Backpressure: inputs toggle while DONE is held
    do_op8("bp", 8'd7, 8'd9, 1'b0, 16'h003F);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sm8 = 1'($urandom);
      @(posedge clk); #1;
      check("bp_p", 64'(p8), 64'h3F);
      check("bp_out_valid", 64'(ov8), 64'(1));
      check("bp_in_ready", 64'(ir8), 64'(0));
    end
    iv8 = 1'b0;
    release8("bp");
    check("bp_p_after", 64'(p8), 64'h3F);

    // Asynchronous reset mid-run, then a clean operation
    a8 = 8'hAB; b8 = 8'hCD; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(ir8), 64'(1));
    check("arst_out_valid", 64'(ov8), 64'(0));
    check("arst_p", 64'(p8), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_p_idle", 64'(p8), 64'(0));
    do_op8("arst_2x3", 8'd2, 8'd3, 1'b0, 16'h0006);
    release8("arst_2x3");

    // Free-run with both handshakes tied high
    iv8 = 1'b1; or8 = 1'b1;
    nprod = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 400 && nprod < 10; cyc++) begin
      if (ov8) begin
        if (fq.size() == 0) check("fr_unexpected", 64'(1), 64'(0));
        else check("fr_p", 64'(p8), fq.pop_front());
        if (last_cyc >= 0) check("fr_spacing", 64'(cyc - last_cyc), 64'(10));
        last_cyc = cyc;
        nprod++;
      end
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sm8 = 1'($urandom);
      if (ir8) fq.push_back(ref_mul(8, 32'(a8), 32'(b8), sm8));
      @(posedge clk); #1;
    end
    check("fr_count", 64'(nprod), 64'(10));
    iv8 = 1'b0; or8 = 1'b0;

    // Exhaustive WIDTH=4, both modes, random stalls on both sides
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30000 && got < 512; cyc++) begin
      or4 = ($urandom_range(0, 3) != 0);
      if (ov4 && or4) begin
        if (q4.size() == 0) check("w4_unexpected", 64'(1), 64'(0));
        else check("w4_p", 64'(p4), q4.pop_front());
        got++;
      end
      if (idx < 512) begin
        idx9 = 9'(idx);
        sm4 = idx9[8];
        a4  = idx9[7:4];
        b4  = idx9[3:0];
        iv4 = ($urandom_range(0, 3) != 0);
      end else begin
        iv4 = 1'b0;
      end
      if (ir4 && iv4) begin
        q4.push_back(ref_mul(4, 32'(a4), 32'(b4), sm4));
        idx++;
      end
      @(posedge clk); #1;
    end
    iv4 = 1'b0; or4 = 1'b0;
    check("w4_count", 64'(got), 64'(512));
    check("w4_queue_empty", 64'(q4.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mul_iter.md
Name: seq_mul_iter

Overview:
Parametrised iterative shift-add multiplier. It is the sequential successor to the team's fixed 4-bit array multiplier. It computes a WIDTH x WIDTH product over WIDTH clock cycles, reusing one WIDTH-bit adder instead of WIDTH-1 ripple adders, and adds a signed mode plus valid/ready handshakes on both input and output. It sits between the operand register file and the result writeback stage.

Parameters:
WIDTH, 8, operand width in bits; legal values 2..32; product width is 2*WIDTH.
CNT_W, $clog2(WIDTH)+1, internal step-counter width; derived, must not be overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  operands and mode presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned.
out_valid  output  1  product available.
out_ready  input  1  consumer accepts the product.
p  output  2*WIDTH  product.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, in_ready = 1, out_valid = 0, p = 0, step counter = 0.
  - Internal accumulator and operand registers = 0.
- Reset during RUN or DONE abandons the operation; no partial result ever appears on p.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1, the block latches |a| and |b| (magnitudes when signed_mode = 1, raw when 0).
  - It also latches result sign = a[MSB] ^ b[MSB] when signed, else 0.
  - It clears the accumulator, sets counter = 0 and moves to RUN.
  - in_valid = 0 keeps the block in IDLE.
- RUN:
  - in_ready = 0; in_valid, a, b and signed_mode are ignored.
  - Each edge performs one step: if multiplier LSB = 1, add the multiplicand to the upper WIDTH bits of the accumulator, keeping the carry.
  - The {carry, accumulator, multiplier} vector then shifts right by 1, and the counter increments.
  - After step WIDTH (counter reaches WIDTH), the block goes to DONE.
  - On the same edge, p is loaded with the magnitude product, two's-complement negated if the result sign = 1, and out_valid is set to 1.
- Latency: operand accept edge E0, steps on edges E1..E_WIDTH; out_valid is high from edge E_WIDTH onward, i.e. WIDTH cycles after accept.
- DONE:
  - out_valid = 1, and p stays stable until the handshake.
  - An edge with out_ready = 1 clears out_valid and returns the block to IDLE; in_ready rises on that same edge.
  - New operands can be accepted on the following edge, so throughput is one product per WIDTH+2 cycles.
  - out_ready = 0 holds DONE indefinitely (backpressure). p, out_valid and in_ready = 0 stay unchanged.
- p holds its last value after leaving DONE; it changes only when the next result loads.
- Arithmetic:
  - Exact, full 2*WIDTH-bit result with no overflow possible.
  - Signed most-negative x most-negative: magnitude 2^(2*WIDTH-2), which is positive and representable.
  - Zero operands still take the full WIDTH cycles (no early termination).
  - A signed result of 0 with sign = 1 negates to 0.
- out_ready asserted while out_valid = 0 has no effect.
- in_valid and out_ready may be tied high. The block then free-runs and out_valid is a single-cycle pulse per product.

Test Plan:
1. WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> out_valid exactly 8 cycles after the accept edge, p=0xFE01, in_ready low for the whole operation.
2. WIDTH=8, signed: -128 x -128 -> p=0x4000; -3 x 5 -> p=0xFFF1; 0x80 x 0x01 -> p=0xFF80. The same bits 0xFD x 0x05 in unsigned mode -> p=0x04F1.
3. Backpressure: complete 7 x 9, hold out_ready=0 for 5 cycles while toggling in_valid, a and b -> p stays 0x003F, out_valid stays 1, in_ready stays 0, and no new operation starts. Release out_ready -> in_ready=1 on the next cycle.
4. Pulse rst_n low asynchronously (between clock edges) at step 4 of a run -> outputs go to their reset values immediately. A new 2 x 3 issued after reset gives p=0x0006 with full 8-cycle latency, with no contamination from the aborted run.
5. WIDTH=4 instance, exhaustive: all 256 operand pairs in both modes, in_valid and out_ready driven with random stalls -> every p equals the behavioural a*b (sign-extended for signed mode), with one result per accepted input, in order.
6. Free-run: in_valid=1 and out_ready=1 tied high for 10 products -> out_valid is a single-cycle pulse every WIDTH+2 cycles, and each result is correct.
